// File: rtl/neuron_mac.sv
// Four-term MAC neuron stage: dot product, bias, fixed-point scale,
// saturating ReLU and one neuron-memory write per group of four terms.
module neuron_mac #(
    parameter int FRAC = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [7:0]  weight_data,
    input  logic [7:0]  neuro_data,
    input  logic [15:0] bias,
    input  logic [7:0]  write_addr_in,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic [1:0]  term_idx,
    output logic [7:0]  neuron_count
);

    // operand capture stage (term acceptance)
    logic               s0_valid;
    logic               s0_first;
    logic               s0_last;
    logic signed [7:0]  s0_w;
    logic signed [7:0]  s0_n;
    logic [15:0]        s0_bias;
    logic [7:0]         s0_addr;

    // product stage
    logic               p_valid;
    logic               p_first;
    logic               p_last;
    logic signed [15:0] p_prod;
    logic [15:0]        p_bias;
    logic [7:0]         p_addr;

    // accumulate stage; a_valid marks a completed (last-tagged) sum
    logic               a_valid;
    logic signed [17:0] acc;
    logic [15:0]        a_bias;
    logic [7:0]         a_addr;

    logic signed [15:0] prod;
    logic signed [17:0] prod_ext;
    logic signed [19:0] sum;
    logic signed [19:0] scaled;
    logic [7:0]         act;

    assign prod     = s0_w * s0_n;
    assign prod_ext = {{2{p_prod[15]}}, p_prod};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            term_idx <= 2'd0;
            s0_valid <= 1'b0;
            s0_first <= 1'b0;
            s0_last  <= 1'b0;
            s0_w     <= '0;
            s0_n     <= '0;
            s0_bias  <= '0;
            s0_addr  <= '0;
        end else if (flush) begin
            term_idx <= 2'd0;
            s0_valid <= 1'b0;
        end else begin
            s0_valid <= in_valid;
            if (in_valid) begin
                term_idx <= term_idx + 2'd1;
                s0_first <= (term_idx == 2'd0);
                s0_last  <= (term_idx == 2'd3);
                s0_w     <= weight_data;
                s0_n     <= neuro_data;
                if (term_idx == 2'd3) begin
                    s0_bias <= bias;
                    s0_addr <= write_addr_in;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_valid <= 1'b0;
            p_first <= 1'b0;
            p_last  <= 1'b0;
            p_prod  <= '0;
            p_bias  <= '0;
            p_addr  <= '0;
        end else if (flush) begin
            p_valid <= 1'b0;
        end else begin
            p_valid <= s0_valid;
            if (s0_valid) begin
                p_first <= s0_first;
                p_last  <= s0_last;
                p_prod  <= prod;
                if (s0_last) begin
                    p_bias <= s0_bias;
                    p_addr <= s0_addr;
                end
            end
        end
    end

    // a first term overwrites the accumulator, so groups never need a clear bubble
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_valid <= 1'b0;
            acc     <= '0;
            a_bias  <= '0;
            a_addr  <= '0;
        end else if (flush) begin
            a_valid <= 1'b0;
        end else begin
            a_valid <= p_valid && p_last;
            if (p_valid) begin
                if (p_first) begin
                    acc <= prod_ext;
                end else begin
                    acc <= acc + prod_ext;
                end
                if (p_last) begin
                    a_bias <= p_bias;
                    a_addr <= p_addr;
                end
            end
        end
    end

    always_comb begin
        sum    = {{2{acc[17]}}, acc} + {{4{a_bias[15]}}, a_bias};
        scaled = sum >>> FRAC;
        act    = 8'd0;
        if (scaled < 0) begin
            act = 8'd0;
        end else if (scaled > 20'sd127) begin
            act = 8'd127;
        end else begin
            act = scaled[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            neuron_count <= '0;
        end else if (flush) begin
            wr_en <= 1'b0;
        end else begin
            wr_en <= a_valid;
            if (a_valid) begin
                wr_addr      <= a_addr;
                wr_data      <= act;
                neuron_count <= neuron_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Four-term multiply-accumulate neuron stage that consumes the operand stream read out of the weight and neuron memories at the addresses produced by the address generator. Every group of four valid weight/neuron pairs becomes one dot product. The stage adds a bias, scales the result, applies a saturating ReLU, and issues one write (address plus data) back into neuron memory. It sits directly downstream of the address generator and its two memories, and drives the neuron-memory write port.

## Interface
- `FRAC`, default 4: arithmetic right-shift applied to the biased sum (fixed-point fraction bits).
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous abort of the current group; high for one or more cycles.
- `in_valid` in 1: `weight_data`/`neuro_data` hold one term this cycle.
- `weight_data` in 8: signed weight operand.
- `neuro_data` in 8: signed neuron operand.
- `bias` in 16: signed bias at product scale, sampled with the 4th term of a group.
- `write_addr_in` in 8: neuron-memory write address, sampled with the 4th term of a group.
- `wr_en` out 1: one-cycle write strobe.
- `wr_addr` out 8: write address, valid while `wr_en` is high.
- `wr_data` out 8: activated result, range 0..127.
- `term_idx` out 2: index (0..3) of the next term to be accepted.
- `neuron_count` out 8: number of completed writes, wraps 255 to 0.

## Operation
- Term counter `term_idx`:
  - Advances by 1 on each `in_valid` and wraps 3 to 0.
  - A term with `term_idx`==0 is "first"; a term with `term_idx`==3 is "last".
- Stage 1 (product): registers the 16-bit signed product, a valid bit, and the first/last tags. On a last term it also captures `bias` and `write_addr_in`.
- Stage 2 (accumulate): 18-bit signed accumulator.
  - On a first term: acc <= product (no clear bubble).
  - Otherwise: acc <= acc + product.
  - The last tag and the captured bias/address propagate with the data.
- Stage 3 (activate), on a last-tagged accumulate:
  - sum = acc + sign-extended bias, 20 bits.
  - s = sum >>> `FRAC`.
  - `wr_data` = 0 if s < 0; 127 if s > 127; otherwise s[7:0].
  - Asserts `wr_en` for exactly one cycle with `wr_addr` = captured address, and increments `neuron_count`.
- Groups may be back-to-back with no idle cycles between them. Gaps in `in_valid` are allowed anywhere inside a group; the counter and pipeline hold.
- `flush`:
  - Next edge: `term_idx` goes to 0 and all stage valid bits clear, so no write is issued for any partial or in-flight group.
  - `neuron_count` is kept.
  - If `flush` and `in_valid` are high in the same cycle, `flush` wins and the term is dropped.
- Reset (`reset_n` low, asynchronous):
  - Outputs: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `term_idx`=0, `neuron_count`=0.
  - Internal: accumulator and all pipeline valid bits are 0.
  - Reset mid-group discards the group.
- When no write is issued, `wr_data`/`wr_addr` hold their last values.

## Timing
- A term accepted at edge N has its product registered at N+1 and is accumulated at N+2.
- Last term accepted at edge N gives `wr_en` high during the cycle after edge N+3. Latency is 3 cycles from last-term acceptance to write.
- Throughput: one term per cycle, one write per 4 terms; with continuous `in_valid`, `wr_en` pulses every 4th cycle.
- `bias` and `write_addr_in` matter only in the cycle the last term is accepted.
- `term_idx` updates on the same edge the term is accepted.

## Test plan
- Basic dot product, `FRAC`=4, bias 0:
  - Stimulus: weights 1,2,3,4; neuro 16,16,16,16; `write_addr_in`=0x10 on term 3.
  - Required: exactly 3 cycles later, `wr_en`=1, `wr_addr`=0x10, `wr_data`=10; `neuron_count`=1.
- ReLU and bias:
  - Weights -1 ×4, neuro 16 ×4 (sum -64) gives `wr_data`=0.
  - Weights 1,2,3,4, neuro 16 ×4, bias -160 gives `wr_data`=0.
  - Same operands with bias +32 gives `wr_data`=12.
- Saturation:
  - 127×127 ×4 gives `wr_data`=127.
  - -128×-128 ×4 (acc 65536) gives `wr_data`=127 with no overflow wrap.
- Back-to-back groups with gaps:
  - Stimulus: 3 consecutive groups with `write_addr_in` 0x10/0x11/0x12, with `in_valid` idle for 2 cycles inside the second group.
  - Required: three single-cycle writes with the correct data and addresses; `neuron_count`=3; no accumulator carry-over between groups.
- Flush:
  - Stimulus: assert `flush` together with term 2.
  - Required: no write is issued; the next 4 terms form a clean group (result 10 for the basic vector); `term_idx` reads 0 after the flush.
- Async reset:
  - Stimulus: pull `reset_n` low mid-cycle during term 2 and while a write is pending.
  - Required: immediately (before the next edge) `wr_en`=0 and all outputs are 0; no write occurs after release until a full new group arrives.
